line_mem_responder: RTL and testbench

- Synthesizable responder for the 128-bit line memory handshake: mem_read/mem_write/mem_addr[31:4]/mem_wdata/mem_rdata/mem_ready.
- Sits on the far side of the I-cache or D-cache miss port. It replaces the behavioural slow memory in gate-level and FPGA builds.
- Holds a line-addressed array and answers each request after a fixed, parameterised latency.
- Counts completed reads and writes, and flags handshake violations by the requester.

---
 rtl/line_mem_responder.sv | 99 +++++++++
 tb/tb_line_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// Line-memory responder for the 128-bit miss-port handshake: fixed-latency
// read/write of a line-addressed array, completion counters and a sticky protocol-error flag.
module line_mem_responder #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              proto_err,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 2);

    state_t              state, state_nxt;
    logic [7:0]          cnt;
    logic                op_wr;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mem [0:(1<<DEPTH_LOG2)-1];

    logic                req, start, enter_resp, busy_viol;
    logic [DEPTH_LOG2-1:0] idx;

    assign req        = mem_read | mem_write;
    assign start      = (state == IDLE) && req;
    assign enter_resp = (state == BUSY) && (cnt == 8'd0);
    assign idx        = addr_q[DEPTH_LOG2-1:0];

    // A write request wins when both lines are up, so the op seen now is simply mem_write.
    assign busy_viol = (state == BUSY) &&
                       (!req || (mem_write != op_wr) ||
                        (mem_addr != addr_q) || (mem_wdata != wdata_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = BUSY;
            BUSY: if (cnt == 8'd0) state_nxt = RESP;
            RESP: state_nxt = GAP;
            GAP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            op_wr     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_rdata <= '0;
            proto_err <= 1'b0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            if (start) begin
                cnt     <= CNT_INIT;
                op_wr   <= mem_write;
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                if (mem_read && mem_write) proto_err <= 1'b1;
            end
            if (state == BUSY && cnt != 8'd0) cnt <= cnt - 8'd1;
            if (busy_viol) proto_err <= 1'b1;
            if (enter_resp && !op_wr) mem_rdata <= mem[idx];
            if (state == RESP) begin
                if (op_wr && wr_cnt != 16'hFFFF)  wr_cnt <= wr_cnt + 16'd1;
                if (!op_wr && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end

    // Storage is not reset; a reset during BUSY leaves state at IDLE so no commit happens.
    always_ff @(posedge clk) begin
        if (enter_resp && op_wr) mem[idx] <= wdata_q;
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: directed scenarios plus randomized
// traffic against a line-array / counter reference model; a LATENCY=2 instance covers saturation.
module tb_line_mem_responder;

    localparam int LAT = 5;

    logic         clk = 0, rst_n = 0;
    logic         mem_read = 0, mem_write = 0;
    logic [27:0]  mem_addr = 0;
    logic [127:0] mem_wdata = 0;
    logic [127:0] mem_rdata;
    logic         mem_ready, proto_err;
    logic [15:0]  rd_cnt, wr_cnt;

    logic         clk_b = 0, rst_nb = 0;
    logic         rd_b = 0, wr_b = 0;
    logic [27:0]  addr_b = 0;
    logic [127:0] wdata_b = 0;
    logic [127:0] rdata_b;
    logic         ready_b, err_b;
    logic [15:0]  rd_cnt_b, wr_cnt_b;

    always #5 clk = ~clk;
    always #2 clk_b = ~clk_b;

    line_mem_responder #(.LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .proto_err(proto_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt));

    line_mem_responder #(.LATENCY(2)) dut_b (
        .clk(clk_b), .rst_n(rst_nb), .mem_read(rd_b), .mem_write(wr_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
        .mem_ready(ready_b), .proto_err(err_b), .rd_cnt(rd_cnt_b), .wr_cnt(wr_cnt_b));

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: line array indexed by the low 8 address bits, counters, sticky error.
    logic [127:0] m_arr [256];
    bit           m_vld [256];
    int           wl[$];
    int           exp_rd = 0, exp_wr = 0;
    bit           exp_err = 0;
    logic [127:0] exp_rdata = 0;
    int           last_rdy_cyc = 0;

    task automatic model_txn(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d);
        int i = int'(a[7:0]);
        if (wr) begin
            m_arr[i] = d;
            if (!m_vld[i]) wl.push_back(i);
            m_vld[i] = 1;
            if (exp_wr < 65535) exp_wr++;
            if (rd) exp_err = 1;
        end else begin
            exp_rdata = m_arr[i];
            if (exp_rd < 65535) exp_rd++;
        end
    endtask

    task automatic apply_reset();
        mem_read = 0; mem_write = 0;
        rst_n = 0;
        repeat (8) @(negedge clk);
        rst_n = 1;
        exp_rd = 0; exp_wr = 0; exp_err = 0; exp_rdata = 0;
        @(negedge clk);
    endtask

    // Drives one request presented while the DUT is idle; returns cycles to ready (0 on timeout).
    task automatic do_req(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d,
                          input bit late, output int lat, output logic [127:0] rdat, output bit dbl);
        mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = d;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mem_ready) begin lat = i; break; end
        end
        rdat = mem_rdata;
        last_rdy_cyc = cyc;
        if (!late) begin mem_read = 0; mem_write = 0; end
        @(negedge clk);
        dbl = mem_ready;
        mem_read = 0; mem_write = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int lat; logic [127:0] r; bit dbl;
        do_req(0, 1, 28'd3, 128'hA5, 0, lat, r, dbl);
        model_txn(0, 1, 28'd3, 128'hA5);
        apply_reset();
        n_tests++;
        if ({mem_rdata, mem_ready, proto_err, rd_cnt, wr_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: rdata=%h ready=%b err=%b rd=%0d wr=%0d, want all 0",
                     mem_rdata, mem_ready, proto_err, rd_cnt, wr_cnt);
        end
        do_req(1, 0, 28'd3, 128'h0, 0, lat, r, dbl);
        model_txn(1, 0, 28'd3, 128'h0);
        n_tests++;
        if (lat !== LAT || dbl !== 1'b0) begin
            n_fail++; $display("FAIL first_read_lat: lat=%0d dbl=%b, want %0d/0", lat, dbl, LAT);
        end
        n_tests++;
        if (r !== 128'hA5 || rd_cnt !== 16'd1) begin
            n_fail++; $display("FAIL first_read_data: rdata=%h rd=%0d, want a5/1", r, rd_cnt);
        end
    endtask

    task automatic test_write_read();
        int lat, c0; logic [127:0] r; bit dbl;
        logic [127:0] d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        do_req(0, 1, 28'd7, d, 0, lat, r, dbl);
        c0 = last_rdy_cyc;
        model_txn(0, 1, 28'd7, d);
        n_tests++;
        if (r !== exp_rdata) begin
            n_fail++; $display("FAIL rdata_on_write: got %h want %h", r, exp_rdata);
        end
        do_req(1, 0, 28'd7, d, 0, lat, r, dbl);
        model_txn(1, 0, 28'd7, d);
        n_tests++;
        if (r !== exp_rdata || wr_cnt !== 16'(exp_wr) || rd_cnt !== 16'(exp_rd) || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_read: rdata=%h wr=%0d rd=%0d err=%b, want %h %0d %0d 0",
                     r, wr_cnt, rd_cnt, proto_err, exp_rdata, exp_wr, exp_rd);
        end
        n_tests++;
        if (last_rdy_cyc - c0 !== LAT + 2) begin
            n_fail++; $display("FAIL ready_spacing: got %0d want %0d", last_rdy_cyc - c0, LAT + 2);
        end
    endtask

    task automatic test_late_deassert();
        int lat; logic [127:0] r; bit dbl, seen;
        apply_reset();
        do_req(1, 0, 28'd7, 128'h0, 1, lat, r, dbl);
        model_txn(1, 0, 28'd7, 128'h0);
        seen = dbl;
        repeat (LAT) begin @(negedge clk); if (mem_ready) seen = 1; end
        n_tests++;
        if (seen !== 1'b0 || rd_cnt !== 16'd1 || lat !== LAT) begin
            n_fail++; $display("FAIL late_deassert: extra_ready=%b rd=%0d lat=%0d, want 0/1/%0d", seen, rd_cnt, lat, LAT);
        end
    endtask

    task automatic test_alias_and_both();
        int lat; logic [127:0] r; bit dbl;
        logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
        do_req(0, 1, 28'h100, d, 0, lat, r, dbl);
        model_txn(0, 1, 28'h100, d);
        do_req(1, 0, 28'h0, 128'h0, 0, lat, r, dbl);
        model_txn(1, 0, 28'h0, 128'h0);
        n_tests++;
        if (r !== d) begin n_fail++; $display("FAIL alias: got %h want %h", r, d); end
        apply_reset();
        d = {$urandom, $urandom, $urandom, $urandom};
        do_req(1, 1, 28'h20, d, 0, lat, r, dbl);
        model_txn(1, 1, 28'h20, d);
        n_tests++;
        if (proto_err !== exp_err || wr_cnt !== 16'(exp_wr) || rd_cnt !== 16'(exp_rd) || r !== exp_rdata) begin
            n_fail++;
            $display("FAIL both_lines: err=%b wr=%0d rd=%0d rdata=%h, want %b %0d %0d %h",
                     proto_err, wr_cnt, rd_cnt, r, exp_err, exp_wr, exp_rd, exp_rdata);
        end
        do_req(1, 0, 28'h20, 128'h0, 0, lat, r, dbl);
        model_txn(1, 0, 28'h20, 128'h0);
        n_tests++;
        if (r !== d) begin n_fail++; $display("FAIL both_as_write: got %h want %h", r, d); end
    endtask

    task automatic test_addr_change();
        int lat; logic [127:0] r, d9, d10; bit dbl;
        d9 = {$urandom, $urandom, $urandom, $urandom};
        d10 = {$urandom, $urandom, $urandom, $urandom};
        do_req(0, 1, 28'd10, d10, 0, lat, r, dbl);
        model_txn(0, 1, 28'd10, d10);
        apply_reset();
        mem_write = 1; mem_addr = 28'd9; mem_wdata = d9;
        repeat (2) @(negedge clk);
        mem_addr = 28'd10;
        lat = 0;
        for (int i = 3; i <= 40; i++) begin
            @(negedge clk);
            if (mem_ready) begin lat = i; break; end
        end
        mem_write = 0;
        repeat (2) @(negedge clk);
        model_txn(0, 1, 28'd9, d9);
        n_tests++;
        if (proto_err !== 1'b1 || lat !== LAT) begin
            n_fail++; $display("FAIL addr_change_err: err=%b lat=%0d, want 1/%0d", proto_err, lat, LAT);
        end
        do_req(1, 0, 28'd9, 128'h0, 0, lat, r, dbl);
        model_txn(1, 0, 28'd9, 128'h0);
        n_tests++;
        if (r !== d9) begin n_fail++; $display("FAIL addr_change_latched: got %h want %h", r, d9); end
        do_req(1, 0, 28'd10, 128'h0, 0, lat, r, dbl);
        model_txn(1, 0, 28'd10, 128'h0);
        n_tests++;
        if (r !== d10) begin n_fail++; $display("FAIL addr_change_other: got %h want %h", r, d10); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [127:0] r; bit dbl;
        do_req(0, 1, 28'd5, 128'h11, 0, lat, r, dbl);
        model_txn(0, 1, 28'd5, 128'h11);
        mem_write = 1; mem_addr = 28'd5; mem_wdata = 128'hFF;
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        n_tests++;
        if (mem_ready !== 1'b0 || rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid: ready=%b rd=%0d wr=%0d, want 0/0/0", mem_ready, rd_cnt, wr_cnt);
        end
        apply_reset();
        do_req(1, 0, 28'd5, 128'h0, 0, lat, r, dbl);
        model_txn(1, 0, 28'd5, 128'h0);
        n_tests++;
        if (r !== 128'h11 || r !== exp_rdata) begin
            n_fail++; $display("FAIL reset_mid_nocommit: got %h want 11", r);
        end
    endtask

    task automatic test_random();
        int lat, bad = 0; logic [127:0] r, d; logic [27:0] a; bit dbl, wr;
        for (int n = 0; n < 60; n++) begin
            wr = (wl.size() == 0) || ($urandom_range(1) == 1);
            if (wr) a = {$urandom_range(255), 8'($urandom_range(15)), 12'h0} >> 8;
            else    a = {20'($urandom), 8'(wl[$urandom_range(wl.size() - 1)])};
            d = {$urandom, $urandom, $urandom, $urandom};
            do_req(!wr, wr, a, d, 0, lat, r, dbl);
            model_txn(!wr, wr, a, d);
            if (lat !== LAT || dbl !== 1'b0 || r !== exp_rdata) begin
                bad++;
                if (bad < 4) $display("FAIL random_txn %0d: lat=%0d rdata=%h, want %0d %h", n, lat, r, LAT, exp_rdata);
            end
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL random_total: %0d bad, want 0", bad); end
        n_tests++;
        if (rd_cnt !== 16'(exp_rd) || wr_cnt !== 16'(exp_wr) || proto_err !== exp_err) begin
            n_fail++;
            $display("FAIL random_counts: rd=%0d wr=%0d err=%b, want %0d %0d %b", rd_cnt, wr_cnt, proto_err, exp_rd, exp_wr, exp_err);
        end
    endtask

    task automatic test_saturation();
        int bad = 0, lat;
        rst_nb = 0;
        repeat (3) @(negedge clk_b);
        rst_nb = 1;
        @(negedge clk_b);
        for (int n = 1; n <= 65540; n++) begin
            rd_b = 1; addr_b = 28'(n);
            lat = 0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk_b);
                if (ready_b) begin lat = i; break; end
            end
            rd_b = 0;
            repeat (2) @(negedge clk_b);
            if (lat !== 2) bad++;
            if (n == 10 || n == 65535 || n == 65540) begin
                n_tests++;
                if (rd_cnt_b !== 16'(n > 65535 ? 65535 : n)) begin
                    n_fail++; $display("FAIL sat_count at %0d: rd=%0d", n, rd_cnt_b);
                end
            end
            if (bad > 0 && lat == 0) break;
        end
        n_tests++;
        if (bad !== 0 || wr_cnt_b !== 16'd0) begin
            n_fail++; $display("FAIL min_latency: %0d bad latencies wr=%0d, want 0/0", bad, wr_cnt_b);
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_write_read();
        test_late_deassert();
        test_alias_and_both();
        test_addr_change();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
